// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: in-order prediction queue, predictor update strobe,
// mispredict redirect and timed flush. Define BRC_STATS_EN to build the statistics counters.
module branch_resolve_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    pred_valid,
  input  logic                    pred_taken,
  input  logic [31:0]             pred_target,
  input  logic [31:0]             pred_fallthru,
  output logic                    pred_ready,
  input  logic                    res_valid,
  input  logic                    res_taken,
  input  logic [31:0]             res_target,
  output logic                    update_valid,
  output logic                    update_taken,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc,
  output logic                    flush,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    protocol_err,
  output logic [15:0]             mispredict_count,
  output logic [15:0]             branch_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_W    = DEPTH[PW:0];
  localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     pending_q, pending_d;
  logic            update_valid_q, update_valid_d;
  logic            update_taken_q, update_taken_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;
  logic            flush_q, flush_d;
  logic            protocol_err_q, protocol_err_d;

  logic            taken_mem    [DEPTH];
  logic [31:0]     target_mem   [DEPTH];
  logic [31:0]     fallthru_mem [DEPTH];

  logic            push, pop, mispredict;
  logic            head_taken;
  logic [31:0]     head_target, head_fallthru, correct_pc;

  // Full queue refuses pushes even when the head retires in the same cycle.
  assign pred_ready = (state_q == RUN) && (pending_q < DEPTH_W);
  assign push       = pred_valid && pred_ready;
  assign pop        = (state_q == RUN) && res_valid && (pending_q != '0);

  assign head_taken    = taken_mem[rd_ptr_q];
  assign head_target   = target_mem[rd_ptr_q];
  assign head_fallthru = fallthru_mem[rd_ptr_q];
  assign correct_pc    = res_taken ? res_target : head_fallthru;
  assign mispredict    = (res_taken != head_taken) || (res_taken && (res_target != head_target));

  always_ff @(posedge clk) begin
    if (push) begin
      taken_mem[wr_ptr_q]    <= pred_taken;
      target_mem[wr_ptr_q]   <= pred_target;
      fallthru_mem[wr_ptr_q] <= pred_fallthru;
    end
  end

  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    pending_d        = pending_q;
    update_valid_d   = 1'b0;
    update_taken_d   = update_taken_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    protocol_err_d   = protocol_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   pending_d = pending_q + (PW+1)'(1);
      2'b01:   pending_d = pending_q - (PW+1)'(1);
      default: pending_d = pending_q;
    endcase

    case (state_q)
      RUN: begin
        flush_d = 1'b0;
        if (res_valid && (pending_q == '0)) protocol_err_d = 1'b1;
        if (pop) begin
          update_valid_d = 1'b1;
          update_taken_d = res_taken;
          // Wrong path: every younger entry, including a same-cycle push, is dropped.
          if (mispredict) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = correct_pc;
            flush_d          = 1'b1;
            state_d          = FLUSH;
            fcnt_d           = FLUSH_LOAD;
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            pending_d        = '0;
          end
        end
      end
      FLUSH: begin
        flush_d = 1'b1;
        if (res_valid) protocol_err_d = 1'b1;
        if (fcnt_q == 4'd0) begin
          state_d = RUN;
          flush_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q          <= RUN;
      fcnt_q           <= 4'd0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      pending_q        <= '0;
      update_valid_q   <= 1'b0;
      update_taken_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
      flush_q          <= 1'b0;
      protocol_err_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      pending_q        <= pending_d;
      update_valid_q   <= update_valid_d;
      update_taken_q   <= update_taken_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      protocol_err_q   <= protocol_err_d;
    end
  end

  assign update_valid   = update_valid_q;
  assign update_taken   = update_taken_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign pending        = pending_q;
  assign protocol_err   = protocol_err_q;

`ifdef BRC_STATS_EN
  logic [15:0] mis_cnt_q, mis_cnt_d;
  logic [15:0] br_cnt_q, br_cnt_d;

  always_comb begin
    mis_cnt_d = mis_cnt_q;
    br_cnt_d  = br_cnt_q;
    if (pop && (br_cnt_q != 16'hFFFF)) br_cnt_d = br_cnt_q + 16'd1;
    if (pop && mispredict && (mis_cnt_q != 16'hFFFF)) mis_cnt_d = mis_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      mis_cnt_q <= 16'h0;
      br_cnt_q  <= 16'h0;
    end else begin
      mis_cnt_q <= mis_cnt_d;
      br_cnt_q  <= br_cnt_d;
    end
  end

  assign mispredict_count = mis_cnt_q;
  assign branch_count     = br_cnt_q;
`else
  assign mispredict_count = 16'h0;
  assign branch_count     = 16'h0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl (DEPTH=4, FLUSH_CYCLES=2); counter
// expectations follow whether BRC_STATS_EN is defined for the build.
module tb_branch_resolve_ctrl;

`ifdef BRC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target, pred_fallthru;
  logic        pred_ready;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        update_valid, update_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [2:0]  pending;
  logic        protocol_err;
  logic [15:0] mispredict_count, branch_count;

  branch_resolve_ctrl #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .Reset(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_fallthru(pred_fallthru),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .update_valid(update_valid), .update_taken(update_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .pending(pending), .protocol_err(protocol_err),
    .mispredict_count(mispredict_count), .branch_count(branch_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic taken; logic [31:0] target; logic [31:0] fallthru;} pred_t;
  typedef struct {logic taken; logic redir; logic [31:0] pc;} exp_t;

  pred_t mq[$];
  exp_t  exp_q[$];
  int    m_left;
  int    vec;
  int    miss;

  function automatic logic [15:0] cnt_exp(input int v);
    return STATS ? 16'(v) : 16'h0;
  endfunction

  task automatic idle_inputs();
    pred_valid = 1'b0; pred_taken = 1'b0; pred_target = 32'h0; pred_fallthru = 32'h0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    exp_q.delete();
    m_left = 0;
  endtask

  // One clock: drive, predict expected update/redirect, then compare after the edge.
  task automatic cycle(input logic pv, input logic pt, input logic [31:0] ptg, input logic [31:0] pf,
                       input logic rv, input logic rt, input logic [31:0] rtg);
    pred_t h;
    exp_t  e;
    bit    run, acc, res, mis;
    pred_valid = pv; pred_taken = pt; pred_target = ptg; pred_fallthru = pf;
    res_valid = rv; res_taken = rt; res_target = rtg;
    run = (m_left == 0);
    acc = pv && run && (mq.size() < 4);
    res = rv && run && (mq.size() > 0);
    mis = 1'b0;
    if (res) begin
      h = mq.pop_front();
      mis = (rt != h.taken) || (rt && (rtg != h.target));
      e.taken = rt; e.redir = mis; e.pc = rt ? rtg : h.fallthru;
      exp_q.push_back(e);
    end
    if (acc) begin
      h.taken = pt; h.target = ptg; h.fallthru = pf;
      mq.push_back(h);
    end
    if (m_left > 0) m_left--;
    else if (mis) begin mq.delete(); m_left = 2; end
    @(posedge clk); #1;
    idle_inputs();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vec++;
      if (update_valid !== 1'b1 || update_taken !== e.taken) begin
        miss++; $display("FAIL update got v=%b t=%b want v=1 t=%b", update_valid, update_taken, e.taken);
      end
      vec++;
      if (redirect_valid !== e.redir) begin
        miss++; $display("FAIL redirect_valid got %b want %b", redirect_valid, e.redir);
      end
      if (e.redir) begin
        vec++;
        if (redirect_pc !== e.pc) begin
          miss++; $display("FAIL redirect_pc got %h want %h", redirect_pc, e.pc);
        end
      end
      $display("resolve: taken=%b redirect=%b pc=%h", e.taken, e.redir, e.pc);
    end else begin
      vec++;
      if (update_valid !== 1'b0 || redirect_valid !== 1'b0) begin
        miss++; $display("FAIL idle_strobes got upd=%b redir=%b want 0 0", update_valid, redirect_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    do_reset();
    vec++; if (pred_ready !== 1'b1) begin miss++; $display("FAIL reset_ready got %b want 1", pred_ready); end
    vec++; if (pending !== 3'd0) begin miss++; $display("FAIL reset_pending got %0d want 0", pending); end
    vec++; if (update_valid !== 1'b0 || update_taken !== 1'b0) begin miss++; $display("FAIL reset_update got %b%b want 00", update_valid, update_taken); end
    vec++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin miss++; $display("FAIL reset_redirect got %b %h want 0 0", redirect_valid, redirect_pc); end
    vec++; if (flush !== 1'b0 || protocol_err !== 1'b0) begin miss++; $display("FAIL reset_flags got flush=%b err=%b want 0 0", flush, protocol_err); end
    vec++; if (mispredict_count !== 16'h0 || branch_count !== 16'h0) begin miss++; $display("FAIL reset_counters got %h %h want 0 0", mispredict_count, branch_count); end
    $display("reset: checked");
  endtask

  task automatic test_correct();
    cycle(1'b1, 1'b1, 32'h100, 32'h24, 1'b0, 1'b0, 32'h0);
    vec++; if (pending !== 3'd1) begin miss++; $display("FAIL correct_push_pending got %0d want 1", pending); end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100);
    vec++; if (pending !== 3'd0 || flush !== 1'b0) begin miss++; $display("FAIL correct_after got pending=%0d flush=%b want 0 0", pending, flush); end
    vec++; if (branch_count !== cnt_exp(1)) begin miss++; $display("FAIL correct_branch_count got %0d want %0d", branch_count, cnt_exp(1)); end
  endtask

  task automatic test_mispredict();
    cycle(1'b1, 1'b0, 32'h80, 32'h40, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200);
    vec++; if (flush !== 1'b1 || pred_ready !== 1'b0) begin miss++; $display("FAIL misp_c1 got flush=%b ready=%b want 1 0", flush, pred_ready); end
    vec++; if (mispredict_count !== cnt_exp(1) || branch_count !== cnt_exp(2)) begin miss++; $display("FAIL misp_counts got %0d %0d want %0d %0d", mispredict_count, branch_count, cnt_exp(1), cnt_exp(2)); end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    vec++; if (flush !== 1'b1 || pred_ready !== 1'b0) begin miss++; $display("FAIL misp_c2 got flush=%b ready=%b want 1 0", flush, pred_ready); end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    vec++; if (flush !== 1'b0 || pred_ready !== 1'b1) begin miss++; $display("FAIL misp_c3 got flush=%b ready=%b want 0 1", flush, pred_ready); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
    vec++; if (pending !== 3'd4 || pred_ready !== 1'b0) begin miss++; $display("FAIL full got pending=%0d ready=%b want 4 0", pending, pred_ready); end
    cycle(1'b1, 1'b1, 32'h3000, 32'h3004, 1'b1, 1'b0, 32'h0);
    vec++; if (pending !== 3'd3 || pred_ready !== 1'b1) begin miss++; $display("FAIL full_nobypass got pending=%0d ready=%b want 3 1", pending, pred_ready); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      vec++; if (pending !== 3'(2 - i)) begin miss++; $display("FAIL b2b_pending got %0d want %0d", pending, 2 - i); end
    end
    vec++; if (branch_count !== cnt_exp(6)) begin miss++; $display("FAIL b2b_branch_count got %0d want %0d", branch_count, cnt_exp(6)); end
  endtask

  task automatic test_flush_discard();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 32'h300 + 32'(i), 32'h500 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h999, 32'h998, 1'b1, 1'b0, 32'h0);
    vec++; if (pending !== 3'd0 || flush !== 1'b1) begin miss++; $display("FAIL discard got pending=%0d flush=%b want 0 1", pending, flush); end
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    vec++; if (pending !== 3'd0 || pred_ready !== 1'b1) begin miss++; $display("FAIL discard_end got pending=%0d ready=%b want 0 1", pending, pred_ready); end
    cycle(1'b1, 1'b1, 32'hA00, 32'hA04, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hA00);
    vec++; if (mispredict_count !== cnt_exp(2) || branch_count !== cnt_exp(8)) begin miss++; $display("FAIL discard_counts got %0d %0d want %0d %0d", mispredict_count, branch_count, cnt_exp(2), cnt_exp(8)); end
  endtask

  task automatic test_protocol();
    vec++; if (protocol_err !== 1'b0) begin miss++; $display("FAIL perr_pre got %b want 0", protocol_err); end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h55);
    vec++; if (protocol_err !== 1'b1 || branch_count !== cnt_exp(8)) begin miss++; $display("FAIL perr_empty got err=%b br=%0d want 1 %0d", protocol_err, branch_count, cnt_exp(8)); end
    cycle(1'b1, 1'b0, 32'h70, 32'h50, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h600);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h600);
    vec++; if (flush !== 1'b1 || protocol_err !== 1'b1) begin miss++; $display("FAIL perr_flush got flush=%b err=%b want 1 1", flush, protocol_err); end
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    vec++; if (protocol_err !== 1'b1 || pred_ready !== 1'b1) begin miss++; $display("FAIL perr_sticky got err=%b ready=%b want 1 1", protocol_err, pred_ready); end
  endtask

  task automatic test_reset_mid_flush();
    cycle(1'b1, 1'b1, 32'h700, 32'h44, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    vec++; if (flush !== 1'b1) begin miss++; $display("FAIL rmf_flush_pre got %b want 1", flush); end
    do_reset();
    vec++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin miss++; $display("FAIL rmf_flags got flush=%b redir=%b want 0 0", flush, redirect_valid); end
    vec++; if (pending !== 3'd0 || pred_ready !== 1'b1) begin miss++; $display("FAIL rmf_queue got pending=%0d ready=%b want 0 1", pending, pred_ready); end
    vec++; if (mispredict_count !== 16'h0 || branch_count !== 16'h0 || protocol_err !== 1'b0) begin miss++; $display("FAIL rmf_counters got %0d %0d err=%b want 0 0 0", mispredict_count, branch_count, protocol_err); end
    cycle(1'b1, 1'b0, 32'hB00, 32'hB04, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    vec++; if (branch_count !== cnt_exp(1) || pending !== 3'd0) begin miss++; $display("FAIL rmf_after got br=%0d pending=%0d want %0d 0", branch_count, pending, cnt_exp(1)); end
  endtask

  initial begin
    vec = 0;
    miss = 0;
    m_left = 0;
    test_reset();
    test_correct();
    test_mispredict();
    test_full();
    test_back_to_back();
    test_flush_discard();
    test_protocol();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequencer between the fetch-stage dynamic branch predictor and the execute-stage branch unit. It queues in-flight predictions in order, retires each against its resolved outcome, and pulses the predictor's update strobe. On a misprediction it issues a single-cycle PC redirect, holds a pipeline flush for a fixed number of cycles and discards all younger wrong-path predictions.

## Interface
- DEPTH, 4: max in-flight predicted branches; power of two, 2..16.
- FLUSH_CYCLES, 2: cycles `flush` is held per mispredict; 1..15.
- clk  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- pred_valid  in  1  fetch issues a predicted branch this cycle.
- pred_taken  in  1  predictor's direction.
- pred_target  in  32  predictor's chosen address.
- pred_fallthru  in  32  sequential PC (PC+4) of that branch.
- pred_ready  out  1  entry accepted when pred_valid && pred_ready.
- res_valid  in  1  execute resolves the oldest outstanding branch.
- res_taken  in  1  actual direction.
- res_target  in  32  actual taken target.
- update_valid  out  1  one-cycle strobe to predictor (its Branch input).
- update_taken  out  1  actual direction for the predictor update.
- redirect_valid  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  32  corrected fetch address.
- flush  out  1  kill younger pipeline stages.
- pending  out  $clog2(DEPTH)+1  queue occupancy.
- protocol_err  out  1  sticky: res_valid with empty queue or during FLUSH.
- mispredict_count  out  16  saturating mispredict counter.
- branch_count  out  16  saturating resolved-branch counter.

## Operation
- Queue: in-order FIFO of {pred_taken, pred_target, pred_fallthru}, DEPTH entries, wrap-around pointers.
- pred_ready = (state == RUN) && (pending < DEPTH); combinational; no bypass when full, even with a simultaneous pop.
- Resolve (RUN, res_valid, pending > 0): pop head; correct_pc = res_taken ? res_target : head.fallthru.
- Mispredict = (res_taken != head.pred_taken) || (res_taken && res_target != head.pred_target).
- Every resolve: update_valid=1, update_taken=res_taken next cycle; branch_count +1.
- Correct resolve: state stays RUN; a simultaneous push also succeeds, so pending is unchanged.
- Mispredict: redirect_pc=correct_pc, redirect_valid=1, flush=1, mispredict_count +1 next cycle; whole queue cleared (pending=0); any push accepted in the same cycle is discarded; go to FLUSH.
- FLUSH: counter loads FLUSH_CYCLES-1 and decrements to 0, then the FSM returns to RUN. pred_ready=0 throughout. Any res_valid in FLUSH is ignored and sets protocol_err.
- res_valid with pending==0 in RUN: ignored; protocol_err set; no update strobe.
- Counters saturate at 16'hFFFF.
- States: RUN -> FLUSH on mispredict; FLUSH -> RUN after FLUSH_CYCLES cycles; Reset -> RUN from any state.

## Timing
- All outputs registered except pred_ready.
- Reset values: pred_ready=1 (comb, after reset), update_valid=0, update_taken=0, redirect_valid=0, redirect_pc=0, flush=0, pending=0, protocol_err=0, counters=0, state=RUN.
- Push at edge N: pending increments after edge N.
- Resolve at edge N: update_valid, redirect_valid and flush assert in cycle N+1.
- redirect_valid lasts exactly 1 cycle.
- flush is high during cycles N+1..N+FLUSH_CYCLES.
- pred_ready is first high again in cycle N+FLUSH_CYCLES+1.
- Back-to-back resolves in RUN sustain 1 per cycle.
- Reset mid-FLUSH: flush, redirect_valid and the queue clear on that edge.

## Configuration
- BRC_STATS_EN defined: mispredict_count and branch_count are implemented as described.
- BRC_STATS_EN undefined: both outputs are tied to 16'h0, no counter flops; all other behaviour is identical.

## Test plan
- Reset, push {taken=1, target=0x100, fallthru=0x24}, resolve taken / 0x100 -> update_valid=1, update_taken=1; redirect_valid=0, flush=0; pending 1 -> 0.
- Push predicted not-taken (fallthru=0x40), resolve taken / 0x200 -> redirect_pc=0x200, redirect_valid for 1 cycle, flush for 2 cycles, mispredict_count=1, pred_ready low 2 cycles.
- Push 4 entries (DEPTH=4) -> pred_ready=0, pending=4. Push and resolve-correct in the same cycle -> push refused, pending=3.
- Queue 3 entries, head mispredicts while pred_valid=1 -> pending=0 next cycle; pushed entry discarded.
- res_valid with empty queue, and again during FLUSH -> no update_valid; protocol_err=1 sticky until Reset.
- Assert Reset in the 1st flush cycle -> next cycle flush=0, pending=0, pred_ready=1, counters=0.
